// File: rtl/fpga_robot_pkg.sv
// Shared robot-controller types: FSM state encoding, command-byte field positions,
// the all-off motor command and a helper that builds an enabled motor command.
package fpga_robot_pkg;

    typedef enum logic [1:0] {
        DRIVE  = 2'd0,
        STOP   = 2'd1,
        BACKUP = 2'd2,
        TURN   = 2'd3
    } state_t;

    localparam int CMD_VLD_BIT  = 7;
    localparam int CMD_SIDE_BIT = 6;
    localparam int CMD_DIR_BIT  = 5;
    localparam int CMD_SPD_MSB  = 4;
    localparam int CMD_SPD_LSB  = 0;

    localparam logic [7:0] REST = 8'h00;

    // Reflex timer width; covers the largest default interval (12M cycles).
    localparam int CNT_W = 24;

    function automatic logic [7:0] motor_cmd(input logic dir, input logic [4:0] spd);
        return {2'b01, dir, spd};
    endfunction

endpackage

// File: rtl/bump_sync.sv
// Two-flop synchroniser for the raw bumper switches, OR-reduced per side.
// Hit outputs lag the raw switches by two clock edges.
module bump_sync (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_bump,
    output logic       o_hit_l,
    output logic       o_hit_r
);

    logic [5:0] r_s1;
    logic [5:0] r_s2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_bump;
            r_s2 <= r_s1;
        end
    end

    assign o_hit_l = |r_s2[2:0];
    assign o_hit_r = |r_s2[5:3];

endmodule

// File: rtl/bump_reflex_ctl.sv
// Motor command register with bump reflex (stop, reverse, spin away); raw bump to STOP in 3 edges.
// Optional command watchdog enabled by defining WATCHDOG_EN; commands are dropped outside DRIVE.
module bump_reflex_ctl
    import fpga_robot_pkg::*;
#(
    parameter int unsigned STOP_CYC = 1200000,
    parameter int unsigned BACK_CYC = 6000000,
    parameter int unsigned TURN_CYC = 4800000,
    parameter logic [4:0]  BACK_SPD = 5'd12,
    parameter logic [4:0]  TURN_SPD = 5'd10,
    parameter int unsigned WDOG_CYC = 12000000
) (
    input  logic       WF_CLK,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    input  logic [5:0] bump,
    output logic [7:0] left_cmd,
    output logic [7:0] right_cmd,
    output logic [1:0] state,
    output logic       wdog_trip
);

    localparam logic [CNT_W-1:0] STOP_LD = CNT_W'(STOP_CYC - 1);
    localparam logic [CNT_W-1:0] BACK_LD = CNT_W'(BACK_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYC - 1);

    logic             w_hit_l;
    logic             w_hit_r;
    logic             w_hit;
    logic             w_spin_right_nxt;
    logic             w_cmd_vld;
    logic [7:0]       w_rx_cmd;
    logic [7:0]       w_back;
    logic [7:0]       w_turn_l;
    logic [7:0]       w_turn_r;
    logic             w_wdog_fire;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_left;
    logic [7:0]       r_right;
    logic             r_spin_right;

    bump_sync u_bump_sync (
        .i_clk   (WF_CLK),
        .i_rst   (rst),
        .i_bump  (bump),
        .o_hit_l (w_hit_l),
        .o_hit_r (w_hit_r)
    );

    assign w_hit            = w_hit_l | w_hit_r;
    // Left-only or both sides spin right; only a right-only hit spins left.
    assign w_spin_right_nxt = w_hit_l | ~w_hit_r;
    assign w_cmd_vld        = rx_strobe & rx_data[CMD_VLD_BIT];
    assign w_rx_cmd         = motor_cmd(rx_data[CMD_DIR_BIT], rx_data[CMD_SPD_MSB:CMD_SPD_LSB]);
    assign w_back           = motor_cmd(1'b0, BACK_SPD);
    assign w_turn_l         = motor_cmd(r_spin_right, TURN_SPD);
    assign w_turn_r         = motor_cmd(~r_spin_right, TURN_SPD);

    always_ff @(posedge WF_CLK) begin
        if (rst) begin
            r_state      <= DRIVE;
            r_cnt        <= '0;
            r_left       <= REST;
            r_right      <= REST;
            r_spin_right <= 1'b1;
        end else begin
            case (r_state)
                DRIVE: begin
                    if (w_hit) begin
                        r_state      <= STOP;
                        r_cnt        <= STOP_LD;
                        r_left       <= REST;
                        r_right      <= REST;
                        r_spin_right <= w_spin_right_nxt;
                    end else if (w_wdog_fire) begin
                        r_left  <= REST;
                        r_right <= REST;
                    end else if (w_cmd_vld) begin
                        if (rx_data[CMD_SIDE_BIT]) begin
                            r_right <= w_rx_cmd;
                        end else begin
                            r_left  <= w_rx_cmd;
                        end
                    end
                end
                STOP: begin
                    if (r_cnt == '0) begin
                        r_state <= BACKUP;
                        r_cnt   <= BACK_LD;
                        r_left  <= w_back;
                        r_right <= w_back;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                BACKUP: begin
                    if (r_cnt == '0) begin
                        r_state <= TURN;
                        r_cnt   <= TURN_LD;
                        r_left  <= w_turn_l;
                        r_right <= w_turn_r;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                TURN: begin
                    // A bump still present (or new) while spinning restarts the whole reflex.
                    if (w_hit) begin
                        r_state      <= STOP;
                        r_cnt        <= STOP_LD;
                        r_left       <= REST;
                        r_right      <= REST;
                        r_spin_right <= w_spin_right_nxt;
                    end else if (r_cnt == '0) begin
                        r_state <= DRIVE;
                        r_cnt   <= '0;
                        r_left  <= REST;
                        r_right <= REST;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= DRIVE;
                    r_cnt   <= '0;
                    r_left  <= REST;
                    r_right <= REST;
                end
            endcase
        end
    end

`ifdef WATCHDOG_EN
    localparam logic [CNT_W-1:0] WDOG_TOP = CNT_W'(WDOG_CYC - 1);
    localparam logic [CNT_W-1:0] WDOG_PRE = CNT_W'(WDOG_CYC - 2);

    logic [CNT_W-1:0] r_wdog;
    logic             r_wdog_trip;

    // Fires on the edge where the counter reaches its terminal value; it then saturates
    // so a silent host sees exactly one trip until the next valid command.
    assign w_wdog_fire = (r_state == DRIVE) && !w_cmd_vld && (r_wdog == WDOG_PRE);

    always_ff @(posedge WF_CLK) begin
        if (rst) begin
            r_wdog      <= '0;
            r_wdog_trip <= 1'b0;
        end else begin
            r_wdog_trip <= w_wdog_fire;
            if ((r_state != DRIVE) || w_cmd_vld) begin
                r_wdog <= '0;
            end else if (r_wdog != WDOG_TOP) begin
                r_wdog <= r_wdog + 1'b1;
            end
        end
    end

    assign wdog_trip = r_wdog_trip;
`else
    logic [31:0] w_unused_wdog;
    assign w_unused_wdog = WDOG_CYC;
    assign w_wdog_fire   = 1'b0;
    assign wdog_trip     = 1'b0;
`endif

    assign left_cmd  = r_left;
    assign right_cmd = r_right;
    assign state     = r_state;

endmodule
